// File: rtl/hdmi_timing_ctrl.sv
// Video timing generator and pixel scheduler: raster counters, run/stop FSM
// that only starts/stops on frame boundaries, registered HDMI outputs and underflow stats.
module hdmi_timing_ctrl #(
  parameter int unsigned H_ACTIVE        = 64,
  parameter int unsigned H_FP            = 4,
  parameter int unsigned H_SYNC          = 4,
  parameter int unsigned H_BP            = 8,
  parameter int unsigned V_ACTIVE        = 64,
  parameter int unsigned V_FP            = 2,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 2,
  parameter logic [31:0] UNDERFLOW_COLOR = 32'h00FF00FF
) (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cnt_clr,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        hdmi_vs,
  output logic        hdmi_hs,
  output logic        hdmi_de,
  output logic [31:0] hdmi_data,
  output logic        sof,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            vs_q, vs_d, hs_q, hs_d, de_q, de_d, sof_q, sof_d;
  logic [31:0]     data_q, data_d;
  logic [7:0]      fcnt_q, fcnt_d;
  logic            uf_q, uf_d;
  logic [15:0]     ucnt_q, ucnt_d;

  logic active, h_last, v_last, frame_last, pix_ready, underflow_px;

  assign active       = (state_q != IDLE);
  assign h_last       = (h_cnt_q == H_LAST);
  assign v_last       = (v_cnt_q == V_LAST);
  assign frame_last   = h_last && v_last;
  assign pix_ready    = active && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign underflow_px = pix_ready && !s_valid;

  // Dropping en on the very last clock goes straight to IDLE so no extra frame starts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = frame_last ? IDLE : STOP;
      STOP:    if (en) state_d = RUN;
               else if (frame_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!active) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  always_comb begin
    vs_d   = !active || ((v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E));
    hs_d   = active && (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
    de_d   = pix_ready;
    sof_d  = active && (h_cnt_q == '0) && (v_cnt_q == '0);
    data_d = '0;
    if (pix_ready) data_d = s_valid ? s_data : UNDERFLOW_COLOR;
    // Counted where the registered vs rises into vertical sync, not on the return to IDLE.
    fcnt_d = fcnt_q;
    if (active && (h_cnt_q == '0) && (v_cnt_q == V_SYNC_S)) fcnt_d = fcnt_q + 8'd1;
    uf_d   = uf_q | underflow_px;
    ucnt_d = ucnt_q;
    if (underflow_px && (ucnt_q != '1)) ucnt_d = ucnt_q + 16'd1;
    if (cnt_clr) begin
      uf_d   = 1'b0;
      ucnt_d = '0;
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      vs_q    <= 1'b1;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      data_q  <= '0;
      fcnt_q  <= '0;
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      data_q  <= data_d;
      fcnt_q  <= fcnt_d;
      uf_q    <= uf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign s_ready       = pix_ready;
  assign busy          = active;
  assign hdmi_vs       = vs_q;
  assign hdmi_hs       = hs_q;
  assign hdmi_de       = de_q;
  assign hdmi_data     = data_q;
  assign sof           = sof_q;
  assign frame_cnt     = fcnt_q;
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Scoreboard bench for hdmi_timing_ctrl: a frame-position model predicts accepted
// pixels and de/sof/busy/s_ready each cycle; feature tasks check timing and counters.
module tb_hdmi_timing_ctrl;
  localparam int H_TOT = 80;
  localparam int FRAME = 5600;
  localparam logic [31:0] UNDER = 32'h00FF00FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, en2, cnt_clr, s_valid;
  logic [31:0] s_data;
  logic s_ready, hdmi_vs, hdmi_hs, hdmi_de, sof, busy, underflow;
  logic [31:0] hdmi_data;
  logic [7:0] frame_cnt;
  logic [15:0] underflow_cnt;
  logic s_ready_2, vs_2, hs_2, de_2, sof_2, busy_2, uf_2;
  logic [31:0] data_2;
  logic [7:0] fc_2;
  logic [15:0] ucnt_2;

  hdmi_timing_ctrl dut (
    .hdmi_clk(clk), .rst_n(rst_n), .en(en), .cnt_clr(cnt_clr), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .hdmi_vs(hdmi_vs), .hdmi_hs(hdmi_hs), .hdmi_de(hdmi_de), .hdmi_data(hdmi_data),
    .sof(sof), .busy(busy), .frame_cnt(frame_cnt), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  hdmi_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .hdmi_clk(clk), .rst_n(rst_n), .en(en2), .cnt_clr(cnt_clr), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_2), .hdmi_vs(vs_2), .hdmi_hs(hs_2), .hdmi_de(de_2), .hdmi_data(data_2),
    .sof(sof_2), .busy(busy_2), .frame_cnt(fc_2), .underflow(uf_2), .underflow_cnt(ucnt_2)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_sof = -1;
  int sof_gap = 0;
  bit m_on = 1'b0;
  int m_t = 0;
  logic [31:0] sb_q[$];

  function automatic bit m_rdy();
    return m_on && ((m_t % H_TOT) < 64) && ((m_t / H_TOT) < 64);
  endfunction

  // One clock: predict from the frame position, advance it, then compare after the edge.
  task automatic tick();
    bit rdy, sof_e, took;
    logic [31:0] exp_px;
    rdy   = rst_n && m_rdy();
    sof_e = rst_n && m_on && (m_t == 0);
    took  = rdy && s_valid;
    if (rdy) sb_q.push_back(s_valid ? s_data : UNDER);
    if (!rst_n) begin m_on = 1'b0; m_t = 0; end
    else if (!m_on) begin if (en) begin m_on = 1'b1; m_t = 0; end end
    else if (m_t == FRAME - 1) begin m_t = 0; m_on = en; end
    else m_t++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    checks++; if (hdmi_de !== rdy) begin errors++; $display("FAIL de_timing cyc=%0d: got %b expected %b", cyc, hdmi_de, rdy); end
    checks++; if (sof !== sof_e) begin errors++; $display("FAIL sof_timing cyc=%0d: got %b expected %b", cyc, sof, sof_e); end
    checks++; if (busy !== m_on) begin errors++; $display("FAIL busy cyc=%0d: got %b expected %b", cyc, busy, m_on); end
    checks++; if (s_ready !== m_rdy()) begin errors++; $display("FAIL s_ready cyc=%0d: got %b expected %b", cyc, s_ready, m_rdy()); end
    if (hdmi_de === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin errors++; $display("FAIL sb_empty cyc=%0d: got data %h with nothing expected", cyc, hdmi_data); end
      else begin
        exp_px = sb_q.pop_front();
        if (hdmi_data !== exp_px) begin errors++; $display("FAIL pixel cyc=%0d: got %h expected %h", cyc, hdmi_data, exp_px); end
      end
    end else begin
      checks++; if (hdmi_data !== 32'h0) begin errors++; $display("FAIL data_blank cyc=%0d: got %h expected 0", cyc, hdmi_data); end
    end
    if (sof === 1'b1) begin
      if (last_sof >= 0) sof_gap = cyc - last_sof;
      last_sof = cyc;
    end
    if (took) s_data = s_data + 32'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (hdmi_vs !== 1'b1) begin errors++; $display("FAIL rst_vs: got %b expected 1", hdmi_vs); end
    checks++; if (hdmi_hs !== 1'b0) begin errors++; $display("FAIL rst_hs: got %b expected 0", hdmi_hs); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst_uf: got %b expected 0", underflow); end
    checks++; if (frame_cnt !== 8'h0) begin errors++; $display("FAIL rst_fc: got %h expected 0", frame_cnt); end
    checks++; if (underflow_cnt !== 16'h0) begin errors++; $display("FAIL rst_ucnt: got %h expected 0", underflow_cnt); end
    checks++; if (vs_2 !== 1'b1 || hs_2 !== 1'b0 || de_2 !== 1'b0 || busy_2 !== 1'b0 || s_ready_2 !== 1'b0)
      begin errors++; $display("FAIL rst_small_ctl: got vs=%b hs=%b de=%b busy=%b rdy=%b expected 1 0 0 0 0", vs_2, hs_2, de_2, busy_2, s_ready_2); end
    checks++; if (fc_2 !== 8'h0 || data_2 !== 32'h0 || sof_2 !== 1'b0) begin errors++; $display("FAIL rst_small_data: got fc=%h data=%h sof=%b expected 0", fc_2, data_2, sof_2); end
  endtask

  task automatic test_timing();
    int de_tot = 0, vs_hi = 0, hs_hi = 0, rdy_hi = 0, line0_de = 0, rise2 = -1;
    bit de_prev = 1'b0;
    rst_n = 1'b1; en = 1'b1; s_valid = 1'b1; s_data = 32'h1000;
    tick();
    checks++; if (hdmi_de !== 1'b0) begin errors++; $display("FAIL first_de_early: got %b expected 0", hdmi_de); end
    tick();
    checks++; if (hdmi_de !== 1'b1) begin errors++; $display("FAIL first_de: got %b expected 1", hdmi_de); end
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL first_sof: got %b expected 1", sof); end
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      if (hdmi_de === 1'b1) begin de_tot++; if (k < H_TOT) line0_de++; end
      if (hdmi_vs === 1'b1) vs_hi++;
      if (hdmi_hs === 1'b1) hs_hi++;
      if (s_ready === 1'b1) rdy_hi++;
      if (k > 0 && hdmi_de === 1'b1 && !de_prev && rise2 < 0) rise2 = k;
      de_prev = (hdmi_de === 1'b1);
    end
    checks++; if (line0_de != 64) begin errors++; $display("FAIL de_per_line: got %0d expected 64", line0_de); end
    checks++; if (rise2 != H_TOT) begin errors++; $display("FAIL line_period: got %0d expected 80", rise2); end
    checks++; if (de_tot != 4096) begin errors++; $display("FAIL de_per_frame: got %0d expected 4096", de_tot); end
    checks++; if (rdy_hi != 4096) begin errors++; $display("FAIL accepted_per_frame: got %0d expected 4096", rdy_hi); end
    checks++; if (vs_hi != 160) begin errors++; $display("FAIL vs_clocks: got %0d expected 160", vs_hi); end
    checks++; if (hs_hi != 280) begin errors++; $display("FAIL hs_clocks: got %0d expected 280", hs_hi); end
    tick();
    checks++; if (sof !== 1'b1) begin errors++; $display("FAIL second_sof: got %b expected 1", sof); end
    checks++; if (sof_gap != FRAME) begin errors++; $display("FAIL frame_period: got %0d expected 5600", sof_gap); end
  endtask

  task automatic test_underflow();
    int n = 0, g = 0;
    s_valid = 1'b0;
    while (n < 10 && g < 1000) begin if (m_rdy()) n++; tick(); g++; end
    s_valid = 1'b1;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b expected 1", underflow); end
    checks++; if (underflow_cnt !== 16'd10) begin errors++; $display("FAIL uf_count: got %0d expected 10", underflow_cnt); end
    g = 0;
    while (!m_rdy() && g < 1000) begin tick(); g++; end
    checks++; if (g >= 1000) begin errors++; $display("FAIL uf_slot_wait: got timeout expected active slot"); end
    s_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0; s_valid = 1'b1;
    checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", underflow_cnt); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_flag: got %b expected 0", underflow); end
  endtask

  task automatic test_back_to_back();
    int g = 0, idle_n = 0;
    bit seen = 1'b0;
    while (m_t < 5 * H_TOT && g < FRAME) begin tick(); g++; end
    en = 1'b0;
    g = 0;
    while (m_t < 40 * H_TOT && g < FRAME) begin tick(); g++; if (busy !== 1'b1) idle_n++; end
    en = 1'b1;
    g = 0;
    while (!seen && g < FRAME + 10) begin tick(); g++; if (busy !== 1'b1) idle_n++; if (sof === 1'b1) seen = 1'b1; end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_sof: got timeout expected sof"); end
    checks++; if (idle_n != 0) begin errors++; $display("FAIL b2b_idle: got %0d idle clocks expected 0", idle_n); end
    checks++; if (sof_gap != FRAME) begin errors++; $display("FAIL b2b_gap: got %0d expected 5600", sof_gap); end
  endtask

  task automatic test_stop();
    int g = 0;
    logic [7:0] fc0, exp_fc;
    while (m_t < 10 * H_TOT && g < FRAME) begin tick(); g++; end
    fc0 = frame_cnt;
    checks++; if (fc0 !== 8'd2) begin errors++; $display("FAIL fc_before_stop: got %0d expected 2", fc0); end
    en = 1'b0;
    g = 0;
    while (busy === 1'b1 && g < FRAME + 10) begin tick(); g++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
    exp_fc = fc0 + 8'd1;
    checks++; if (frame_cnt !== exp_fc) begin errors++; $display("FAIL stop_fc: got %0d expected %0d", frame_cnt, exp_fc); end
    tick();
    checks++; if (hdmi_vs !== 1'b1) begin errors++; $display("FAIL idle_vs: got %b expected 1", hdmi_vs); end
    tick();
    checks++; if (hdmi_vs !== 1'b1 || hdmi_hs !== 1'b0) begin errors++; $display("FAIL idle_hold: got vs=%b hs=%b expected 1 0", hdmi_vs, hdmi_hs); end
  endtask

  task automatic test_reset_midframe();
    int g = 0, n = 0;
    en = 1'b1;
    while (!(m_on && m_t == 30 * H_TOT + 20) && g < 3000) begin
      if (m_rdy() && n < 3) begin s_valid = 1'b0; n++; end else s_valid = 1'b1;
      tick(); g++;
    end
    s_valid = 1'b1;
    checks++; if (underflow_cnt !== 16'd3 || underflow !== 1'b1) begin errors++; $display("FAIL pre_rst_uf: got %0d/%b expected 3/1", underflow_cnt, underflow); end
    rst_n = 1'b0;
    tick();
    checks++; if (hdmi_vs !== 1'b1) begin errors++; $display("FAIL mid_rst_vs: got %b expected 1", hdmi_vs); end
    checks++; if (hdmi_hs !== 1'b0 || hdmi_de !== 1'b0) begin errors++; $display("FAIL mid_rst_hsde: got %b %b expected 0 0", hdmi_hs, hdmi_de); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b %b expected 0 0", busy, s_ready); end
    checks++; if (frame_cnt !== 8'h0) begin errors++; $display("FAIL mid_rst_fc: got %0d expected 0", frame_cnt); end
    checks++; if (underflow !== 1'b0 || underflow_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_uf: got %b/%0d expected 0/0", underflow, underflow_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (hdmi_de !== 1'b0) begin errors++; $display("FAIL restart_de_early: got %b expected 0", hdmi_de); end
    tick();
    checks++; if (hdmi_de !== 1'b1 || sof !== 1'b1) begin errors++; $display("FAIL restart_sof: got de=%b sof=%b expected 1 1", hdmi_de, sof); end
    checks++; if (hdmi_vs !== 1'b0) begin errors++; $display("FAIL restart_vs: got %b expected 0", hdmi_vs); end
    en = 1'b0;
  endtask

  task automatic test_wrap();
    int nchg = 0, sof_n = 0, de_n = 0;
    logic [7:0] prev, exp_fc;
    prev = fc_2;
    en2 = 1'b1;
    for (int i = 0; i < 9500 && nchg < 256; i++) begin
      tick();
      if (sof_2 === 1'b1) sof_n++;
      if (de_2 === 1'b1) de_n++;
      if (fc_2 !== prev) begin
        nchg++;
        exp_fc = prev + 8'd1;
        checks++; if (fc_2 !== exp_fc) begin errors++; $display("FAIL fc_step: got %0d expected %0d", fc_2, exp_fc); end
        if (nchg == 255) begin checks++; if (fc_2 !== 8'd255) begin errors++; $display("FAIL fc_255: got %0d expected 255", fc_2); end end
        if (nchg == 256) begin checks++; if (fc_2 !== 8'd0) begin errors++; $display("FAIL fc_wrap: got %0d expected 0", fc_2); end end
        prev = fc_2;
      end
    end
    checks++; if (nchg != 256) begin errors++; $display("FAIL wrap_frames: got %0d expected 256", nchg); end
    checks++; if (sof_n != 256) begin errors++; $display("FAIL wrap_sof: got %0d expected 256", sof_n); end
    checks++; if (de_n != 2048) begin errors++; $display("FAIL wrap_de: got %0d expected 2048", de_n); end
    checks++; if (uf_2 !== 1'b0 || ucnt_2 !== 16'h0) begin errors++; $display("FAIL wrap_uf: got %b/%0d expected 0/0", uf_2, ucnt_2); end
    en2 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; cnt_clr = 1'b0; s_valid = 1'b0; s_data = '0;
    test_reset();
    test_timing();
    test_underflow();
    test_back_to_back();
    test_stop();
    test_reset_midframe();
    test_wrap();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
